// File: rtl/mem_pkg.sv
// mem_pkg
// Shared types for the data-memory arbiter: access sizes, requester ids
// and the one-entry response record that travels from a granted load or
// fetch to the cycle in which its data comes back from the banks.

package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } mem_size_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    // Everything the return path needs to steer and extend the bank data
    typedef struct packed {
        port_e     src;
        mem_size_e size;
        logic [1:0] off;
        logic      is_unsigned;
        logic      err;
    } resp_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Groups the fetch port, the load/store port and the bank-array port of
// the memory arbiter.
//   slave  : the arbiter (takes requests and bank_rdata, drives grants,
//            responses and the bank write/address/data signals)
//   master : the core pipeline plus bank array side
// Parameter AW is the bank row-address width.

interface mem_arbiter_if #(
    parameter int AW = 12
);
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [3:0]    bank_we;
    logic [AW-1:0] bank_addr;
    logic [31:0]   bank_wdata;
    logic [31:0]   bank_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        input  bank_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output bank_we, bank_addr, bank_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        output bank_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  bank_we, bank_addr, bank_wdata
    );

endinterface

// File: rtl/load_formatter.sv
// load_formatter
// Picks the addressed byte or halfword out of a 32-bit bank read and
// sign- or zero-extends it. Word accesses pass straight through.
//   rdata_i    : raw word from the four banks (lane b = bank b)
//   size_i     : access size
//   off_i      : byte offset within the word
//   unsigned_i : 1 = zero-extend, 0 = sign-extend
//   data_o     : extended result

module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  mem_size_e   size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension from bit 7 or bit 15
    always_comb begin
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            SIZE_B:  data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            SIZE_H:  data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the four byte-wide data banks between instruction fetch and
// load/store. One requester is granted per cycle; stores commit at the
// grant edge, loads and fetches return formatted data one cycle later.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch port, load/store port and bank-array port

module mem_arbiter
    import mem_pkg::*;
#(
    parameter int DATA_DEPTH = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam int AW = $clog2(DATA_DEPTH);

    port_e       prio_q, prio_d;
    logic        valid_q, valid_d;
    resp_t       resp_q, resp_d;
    logic        grant_if, grant_d;
    logic [31:0] sel_addr;
    logic [1:0]  off;
    logic        range_err, d_fault, if_fault, fault;
    mem_size_e   d_size_e;
    logic [31:0] fmt_data;
    logic        if_resp, d_resp;

    // Round-robin on contention only; grants are masked while in reset so
    // that nothing reaches the banks before the core is released.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        prio_d   = prio_q;
        if (rst_n) begin
            if (bus.if_req && bus.d_req) begin
                grant_d  = (prio_q == PORT_D);
                grant_if = ~grant_d;
                prio_d   = grant_d ? PORT_IF : PORT_D;
            end else begin
                grant_if = bus.if_req;
                grant_d  = bus.d_req;
            end
        end
    end

    assign sel_addr  = grant_d ? bus.d_addr : bus.if_addr;
    assign off       = sel_addr[1:0];
    assign range_err = |sel_addr[31:AW+2];
    assign d_size_e  = mem_size_e'(bus.d_size);
    assign if_fault  = range_err | (off != 2'b00);
    assign fault     = grant_d ? d_fault : if_fault;

    // Data-port fault: illegal size, misalignment, or beyond the banks
    always_comb begin
        d_fault = range_err;
        case (d_size_e)
            SIZE_B:  d_fault = range_err;
            SIZE_H:  d_fault = range_err | off[0];
            SIZE_W:  d_fault = range_err | (off != 2'b00);
            default: d_fault = 1'b1;
        endcase
    end

    // Store lane replication and byte enables; faulting stores write nothing
    always_comb begin
        bus.bank_we = 4'b0000;
        case (d_size_e)
            SIZE_B:  bus.bank_wdata = {4{bus.d_wdata[7:0]}};
            SIZE_H:  bus.bank_wdata = {2{bus.d_wdata[15:0]}};
            default: bus.bank_wdata = bus.d_wdata;
        endcase
        if (grant_d && bus.d_we && !d_fault) begin
            case (d_size_e)
                SIZE_B:  bus.bank_we = 4'b0001 << off;
                SIZE_H:  bus.bank_we = off[1] ? 4'b1100 : 4'b0011;
                default: bus.bank_we = 4'b1111;
            endcase
        end
    end

    assign bus.bank_addr = sel_addr[AW+1:2];
    assign bus.if_gnt    = grant_if;
    assign bus.d_gnt     = grant_d;

    // Every granted access owes a response except a clean store
    always_comb begin
        valid_d            = (grant_if | grant_d) & ~(grant_d & bus.d_we & ~d_fault);
        resp_d.src         = grant_d ? PORT_D : PORT_IF;
        resp_d.size        = grant_d ? d_size_e : SIZE_W;
        resp_d.off         = off;
        resp_d.is_unsigned = grant_d & bus.d_unsigned;
        resp_d.err         = fault;
    end

    // Arbitration priority and the single in-flight response slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q  <= PORT_D;
            valid_q <= 1'b0;
            resp_q  <= '0;
        end else begin
            prio_q  <= prio_d;
            valid_q <= valid_d;
            resp_q  <= resp_d;
        end
    end

    load_formatter u_load_formatter (
        .rdata_i    (bus.bank_rdata),
        .size_i     (resp_q.size),
        .off_i      (resp_q.off),
        .unsigned_i (resp_q.is_unsigned),
        .data_o     (fmt_data)
    );

    // Route the response to its source; data is zero unless valid and clean
    assign if_resp       = valid_q & (resp_q.src == PORT_IF);
    assign d_resp        = valid_q & (resp_q.src == PORT_D);
    assign bus.if_rvalid = if_resp;
    assign bus.d_rvalid  = d_resp;
    assign bus.if_err    = if_resp & resp_q.err;
    assign bus.d_err     = d_resp & resp_q.err;
    assign bus.if_rdata  = (if_resp && !resp_q.err) ? fmt_data : 32'h0;
    assign bus.d_rdata   = (d_resp && !resp_q.err) ? fmt_data : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives mem_arbiter with directed and random traffic, models the bank
// array as the environment, and compares every cycle against a byte-level
// reference memory with a simple grant/response predictor.

module tb_mem_arbiter;

    localparam int DEPTH     = 4096;
    localparam int AW        = $clog2(DEPTH);
    localparam int MEM_BYTES = 4 * DEPTH;

    logic clk;
    logic rst_n;

    logic        ifReq;
    logic [31:0] ifAddr;
    logic        dReq, dWe, dUns;
    logic [1:0]  dSize;
    logic [31:0] dAddr, dWdata;

    logic [7:0]  bankMem [4][DEPTH];
    logic [31:0] bankRdata;
    logic        clearMem;

    logic [7:0]  refMem [MEM_BYTES];
    logic        prioD;
    logic        expValid, expIsIf, expErr;
    logic [31:0] expData;

    logic [31:0] lastDData, lastIfData, lastWdata;
    logic        lastDErr, lastIfErr, lastDGnt;
    logic [3:0]  lastWe;
    logic [3:0]  grantSeq;

    int checkCount = 0;
    int errorCount = 0;

    mem_arbiter_if #(.AW(AW)) ifc ();

    mem_arbiter #(.DATA_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    assign ifc.if_req     = ifReq;
    assign ifc.if_addr    = ifAddr;
    assign ifc.d_req      = dReq;
    assign ifc.d_we       = dWe;
    assign ifc.d_size     = dSize;
    assign ifc.d_unsigned = dUns;
    assign ifc.d_addr     = dAddr;
    assign ifc.d_wdata    = dWdata;
    assign ifc.bank_rdata = bankRdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank array: synchronous write per lane, registered read of the row
    always @(posedge clk) begin
        if (clearMem) begin
            for (int b = 0; b < 4; b++)
                for (int r = 0; r < DEPTH; r++)
                    bankMem[b][r] <= 8'h00;
            bankRdata <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (ifc.bank_we[b])
                    bankMem[b][ifc.bank_addr] <= ifc.bank_wdata[8*b +: 8];
                bankRdata[8*b +: 8] <= bankMem[b][ifc.bank_addr];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // Little-endian read from the reference byte memory with extension
    function automatic logic [31:0] refLoad(input logic [31:0] addr, input int nBytes, input logic isUns);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < nBytes; i++)
            v = v | (32'(refMem[addr + 32'(i)]) << (8 * i));
        if (!isUns && nBytes < 4 && v[8*nBytes-1])
            v = v | (32'hFFFF_FFFF << (8 * nBytes));
        return v;
    endfunction

    function automatic logic dataFault(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'd3) return 1'b1;
        if (addr >= 32'(MEM_BYTES)) return 1'b1;
        return (addr % (32'd1 << size)) != 0;
    endfunction

    function automatic logic [31:0] randAddr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 15) == 0)
            a = a | (32'd1 << $urandom_range(14, 31));
        return a;
    endfunction

    // One clock: check responses and grants at the falling edge, advance
    // the reference model, then release whichever request was granted.
    task automatic stepCycle();
        logic        gIf, gD, fault, nValid, nIsIf, nErr;
        logic [31:0] nData;
        logic [3:0]  expWe;
        int          nBytes;
        @(negedge clk);
        checkOutput("if_rvalid", 32'(ifc.if_rvalid), 32'(expValid & expIsIf));
        checkOutput("if_rdata", ifc.if_rdata, (expValid & expIsIf) ? expData : 32'h0);
        checkOutput("if_err", 32'(ifc.if_err), 32'(expValid & expIsIf & expErr));
        checkOutput("d_rvalid", 32'(ifc.d_rvalid), 32'(expValid & ~expIsIf));
        checkOutput("d_rdata", ifc.d_rdata, (expValid & ~expIsIf) ? expData : 32'h0);
        checkOutput("d_err", 32'(ifc.d_err), 32'(expValid & ~expIsIf & expErr));
        if (ifc.d_rvalid) begin
            lastDData = ifc.d_rdata;
            lastDErr  = ifc.d_err;
        end
        if (ifc.if_rvalid) begin
            lastIfData = ifc.if_rdata;
            lastIfErr  = ifc.if_err;
        end

        gIf = 1'b0; gD = 1'b0; nValid = 1'b0; nIsIf = 1'b0; nErr = 1'b0;
        nData = 32'h0; expWe = 4'h0; fault = 1'b0;
        if (rst_n) begin
            if (ifReq && dReq) begin
                gD    = prioD;
                gIf   = ~prioD;
                prioD = ~prioD;
            end else begin
                gIf = ifReq;
                gD  = dReq;
            end
        end
        checkOutput("if_gnt", 32'(ifc.if_gnt), 32'(gIf));
        checkOutput("d_gnt", 32'(ifc.d_gnt), 32'(gD));
        lastDGnt = ifc.d_gnt;
        if (ifc.d_gnt) begin
            lastWe    = ifc.bank_we;
            lastWdata = ifc.bank_wdata;
        end

        if (gIf) begin
            fault  = (ifAddr[1:0] != 2'b00) || (ifAddr >= 32'(MEM_BYTES));
            nValid = 1'b1;
            nIsIf  = 1'b1;
            nErr   = fault;
            nData  = fault ? 32'h0 : refLoad(ifAddr, 4, 1'b1);
            if (!fault) checkOutput("if_bank_addr", 32'(ifc.bank_addr), ifAddr >> 2);
        end
        if (gD) begin
            fault  = dataFault(dAddr, dSize);
            nBytes = 1 << dSize;
            if (!fault) checkOutput("d_bank_addr", 32'(ifc.bank_addr), dAddr >> 2);
            if (dWe && !fault) begin
                expWe = 4'((1 << nBytes) - 1) << dAddr[1:0];
                for (int i = 0; i < nBytes; i++) begin
                    refMem[dAddr + 32'(i)] = dWdata[8*i +: 8];
                    checkOutput("bank_wdata_lane", 32'(ifc.bank_wdata[8*(int'(dAddr[1:0]) + i) +: 8]),
                                32'(dWdata[8*i +: 8]));
                end
            end else begin
                nValid = 1'b1;
                nErr   = fault;
                nData  = fault ? 32'h0 : refLoad(dAddr, nBytes, dUns);
            end
        end
        checkOutput("bank_we", 32'(ifc.bank_we), 32'(expWe));

        @(posedge clk);
        expValid = nValid;
        expIsIf  = nIsIf;
        expErr   = nErr;
        expData  = nData;
        #1;
        if (gIf) ifReq = 1'b0;
        if (gD)  dReq  = 1'b0;
    endtask

    // Raise the requested ports and step until both have been granted
    task automatic applyStimulus(input logic doIf, input logic [31:0] fAddr,
                                 input logic doD, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (doIf) begin
            ifReq  = 1'b1;
            ifAddr = fAddr;
        end
        if (doD) begin
            dReq   = 1'b1;
            dWe    = we;
            dSize  = size;
            dUns   = uns;
            dAddr  = addr;
            dWdata = wdata;
        end
        for (int c = 0; c < 10 && (ifReq || dReq); c++)
            stepCycle();
        if (ifReq || dReq) begin
            checkOutput("grant_timeout", 32'(ifReq | dReq), 32'h0);
            ifReq = 1'b0;
            dReq  = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; clearMem = 1'b1;
        ifReq = 1'b0; ifAddr = 32'h0;
        dReq = 1'b0; dWe = 1'b0; dUns = 1'b0; dSize = 2'b10; dAddr = 32'h0; dWdata = 32'h0;
        prioD = 1'b1; expValid = 1'b0; expIsIf = 1'b0; expErr = 1'b0; expData = 32'h0;
        lastDData = 32'h0; lastIfData = 32'h0; lastWdata = 32'h0;
        lastDErr = 1'b0; lastIfErr = 1'b0; lastDGnt = 1'b0; lastWe = 4'h0; grantSeq = 4'h0;
        for (int i = 0; i < MEM_BYTES; i++) refMem[i] = 8'h00;

        for (int c = 0; c < 3; c++) stepCycle();
        clearMem = 1'b0;
        rst_n    = 1'b1;

        $display("[TB] store/load formatting");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        checkOutput("plan_st_word_we", 32'(lastWe), 32'h0000000F);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        stepCycle();
        checkOutput("plan_ld_word", lastDData, 32'hDEADBEEF);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        stepCycle();
        checkOutput("plan_ld_byte_s", lastDData, 32'hFFFFFFDE);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
        stepCycle();
        checkOutput("plan_ld_byte_u", lastDData, 32'h000000DE);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        stepCycle();
        checkOutput("plan_ld_half_s", lastDData, 32'hFFFFDEAD);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0000005A);
        checkOutput("plan_st_byte_we", 32'(lastWe), 32'h00000002);
        checkOutput("plan_st_byte_wdata", lastWdata, 32'h5A5A5A5A);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        stepCycle();
        checkOutput("plan_reload", lastDData, 32'hDEAD5AEF);

        $display("[TB] contention");
        for (int i = 0; i < 4; i++) begin
            ifReq = 1'b1; ifAddr = 32'h100;
            dReq = 1'b1; dWe = 1'b0; dSize = 2'b10; dUns = 1'b0; dAddr = 32'h104;
            stepCycle();
            grantSeq[i] = lastDGnt;
        end
        ifReq = 1'b0; dReq = 1'b0;
        stepCycle();
        checkOutput("plan_grant_order", 32'(grantSeq), 32'h00000005);

        $display("[TB] faults");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        checkOutput("plan_flt_misal_we", 32'(lastWe), 32'h0);
        stepCycle();
        checkOutput("plan_flt_misal_err", 32'(lastDErr), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 2'b11, 1'b0, 32'h100, 32'h12345678);
        checkOutput("plan_flt_size_we", 32'(lastWe), 32'h0);
        stepCycle();
        checkOutput("plan_flt_size_err", 32'(lastDErr), 32'h1);
        checkOutput("plan_flt_size_data", lastDData, 32'h0);
        applyStimulus(1'b1, 32'h2, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        stepCycle();
        checkOutput("plan_flt_fetch_err", 32'(lastIfErr), 32'h1);
        checkOutput("plan_flt_fetch_data", lastIfData, 32'h0);

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            if (!ifReq && $urandom_range(0, 2) != 0) begin
                ifReq  = 1'b1;
                ifAddr = ($urandom_range(0, 3) == 0) ? randAddr() : (randAddr() & ~32'h3);
            end
            if (!dReq && $urandom_range(0, 2) != 0) begin
                dReq   = 1'b1;
                dWe    = 1'($urandom_range(0, 1));
                dSize  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                dUns   = 1'($urandom_range(0, 1));
                dAddr  = randAddr();
                if ($urandom_range(0, 3) != 0)
                    dAddr = dAddr & ~((32'd1 << dSize) - 32'd1);
                dWdata = $urandom;
            end
            stepCycle();
        end
        for (int c = 0; c < 4 && (ifReq || dReq); c++) stepCycle();
        ifReq = 1'b0; dReq = 1'b0;
        stepCycle();

        $display("[TB] reset during a pending load");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        rst_n    = 1'b0;
        expValid = 1'b0;
        prioD    = 1'b1;
        ifReq = 1'b1; ifAddr = 32'h100;
        dReq = 1'b1; dWe = 1'b1; dSize = 2'b10; dUns = 1'b0; dAddr = 32'h200; dWdata = 32'h12345678;
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        checkOutput("plan_reset_prio", 32'(lastDGnt), 32'h1);
        for (int c = 0; c < 4 && (ifReq || dReq); c++) stepCycle();
        stepCycle();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
